// File: rtl/sched_mac_filtros_pkg.sv
// Shared constants for the equalizer MAC scheduler: stage indices, FSM encoding
// and default sizing.
package sched_mac_filtros_pkg;

  localparam int N_STAGES_DEF = 6;
  localparam int N_TAPS_DEF   = 5;
  localparam int SEL_W_DEF    = 4;

  localparam logic [2:0] ST_LP200 = 3'd0;
  localparam logic [2:0] ST_LP5K  = 3'd1;
  localparam logic [2:0] ST_LP20K = 3'd2;
  localparam logic [2:0] ST_HP20  = 3'd3;
  localparam logic [2:0] ST_HP200 = 3'd4;
  localparam logic [2:0] ST_HP5K  = 3'd5;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_CAPT = 3'd3;
  localparam logic [2:0] S_DESP = 3'd4;

endpackage

// File: rtl/sched_mac_filtros_busca_etapa.sv
// Priority finder: lowest enabled stage strictly above 'actual', or the lowest
// enabled stage overall when desde_inicio is set (index -1 at frame start).
module busca_etapa #(
  parameter int N_STAGES = 6
) (
  input  logic [N_STAGES-1:0] en,
  input  logic                desde_inicio,
  input  logic [2:0]          actual,
  output logic [2:0]          siguiente,
  output logic                valido
);

  always_comb begin
    siguiente = '0;
    valido    = 1'b0;
    // Descending scan so the lowest qualifying index is the one that sticks.
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (en[i] && (desde_inicio || (3'(i) > actual))) begin
        siguiente = 3'(i);
        valido    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sched_mac_filtros.sv
// Per-sample scheduler for the six equalizer stages: CLR, N_TAPS x MAC, CAPT,
// DESP for every enabled stage in ascending order, with one-deep sample pending.
module sched_mac_filtros
  import sched_mac_filtros_pkg::*;
#(
  parameter int N_STAGES = N_STAGES_DEF,
  parameter int N_TAPS   = N_TAPS_DEF,
  parameter int SEL_W    = SEL_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                muestra_lista,
  input  logic [N_STAGES-1:0] stage_en,
  input  logic                clr_overrun,
  output logic [2:0]          stage_id,
  output logic                rst_acum,
  output logic                leer,
  output logic [SEL_W-1:0]    sel,
  output logic                leer_y,
  output logic                desp,
  output logic [N_STAGES-1:0] stage_done,
  output logic                ocupado,
  output logic                trama_lista,
  output logic                overrun,
  output logic [2:0]          estado_dbg
);

  logic [2:0]          estado;
  logic [2:0]          stage_q;
  logic [N_STAGES-1:0] en_lat;
  logic [SEL_W-1:0]    tap;
  logic                pend;
  logic                overrun_q;
  logic                trama_vacia;

  logic [2:0] ini_idx, sig_idx;
  logic       ini_ok, sig_ok;
  logic       final_desp;

  busca_etapa #(.N_STAGES(N_STAGES)) u_ini (
    .en(stage_en), .desde_inicio(1'b1), .actual(3'd0),
    .siguiente(ini_idx), .valido(ini_ok)
  );

  busca_etapa #(.N_STAGES(N_STAGES)) u_sig (
    .en(en_lat), .desde_inicio(1'b0), .actual(stage_q),
    .siguiente(sig_idx), .valido(sig_ok)
  );

  assign final_desp = (estado == S_DESP) && !sig_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado      <= S_IDLE;
      stage_q     <= '0;
      en_lat      <= '0;
      tap         <= '0;
      pend        <= 1'b0;
      overrun_q   <= 1'b0;
      trama_vacia <= 1'b0;
    end else begin
      trama_vacia <= 1'b0;
      case (estado)
        S_IDLE: begin
          if (muestra_lista) begin
            en_lat <= stage_en;
            if (ini_ok) begin
              stage_q <= ini_idx;
              estado  <= S_CLR;
            end else begin
              trama_vacia <= 1'b1;
            end
          end
        end
        S_CLR: begin
          tap    <= '0;
          estado <= S_MAC;
        end
        S_MAC: begin
          if (tap == SEL_W'(N_TAPS - 1)) estado <= S_CAPT;
          else                           tap    <= tap + 1'b1;
        end
        S_CAPT: estado <= S_DESP;
        S_DESP: begin
          if (sig_ok) begin
            stage_q <= sig_idx;
            estado  <= S_CLR;
          end else if (pend || muestra_lista) begin
            // Back-to-back frame: relatch the mask and skip the IDLE cycle.
            en_lat <= stage_en;
            if (ini_ok) begin
              stage_q <= ini_idx;
              estado  <= S_CLR;
            end else begin
              trama_vacia <= 1'b1;
              estado      <= S_IDLE;
            end
          end else begin
            estado <= S_IDLE;
          end
        end
        default: estado <= S_IDLE;
      endcase

      // One sample can wait; a second one arriving while waiting is lost.
      if (ocupado && muestra_lista && !final_desp && !pend) pend <= 1'b1;
      else if (final_desp && pend && !muestra_lista)        pend <= 1'b0;

      if (ocupado && muestra_lista && pend && !final_desp) overrun_q <= 1'b1;
      else if (clr_overrun)                                overrun_q <= 1'b0;
    end
  end

  assign ocupado     = (estado != S_IDLE);
  assign stage_id    = stage_q;
  assign rst_acum    = (estado == S_CLR);
  assign leer        = (estado == S_MAC);
  assign sel         = (estado == S_MAC) ? tap : '0;
  assign leer_y      = (estado == S_CAPT);
  assign desp        = (estado == S_DESP);
  assign stage_done  = (estado == S_DESP) ? (N_STAGES'(1) << stage_q) : '0;
  assign trama_lista = final_desp || trama_vacia;
  assign overrun     = overrun_q;
  assign estado_dbg  = estado;

endmodule

// File: tb/tb_sched_mac_filtros.sv
// Bench for sched_mac_filtros: directed frames, expected per-cycle strobe words
// queued by the drivers and checked by an independent negedge monitor.
module tb_sched_mac_filtros;
  import sched_mac_filtros_pkg::*;

  localparam int NT  = 5;
  localparam int W   = 36;
  localparam int BIG = 1 << 30;

  logic       clk;
  logic       rst;
  logic       muestra_lista;
  logic [5:0] stage_en;
  logic       clr_overrun;
  logic [2:0] stage_id;
  logic       rst_acum, leer, leer_y, desp, ocupado, trama_lista, overrun;
  logic [3:0] sel;
  logic [5:0] stage_done;
  logic [2:0] estado_dbg;

  sched_mac_filtros #(.N_STAGES(6), .N_TAPS(NT), .SEL_W(4)) dut (
    .clk(clk), .rst(rst), .muestra_lista(muestra_lista), .stage_en(stage_en),
    .clr_overrun(clr_overrun), .stage_id(stage_id), .rst_acum(rst_acum),
    .leer(leer), .sel(sel), .leer_y(leer_y), .desp(desp),
    .stage_done(stage_done), .ocupado(ocupado), .trama_lista(trama_lista),
    .overrun(overrun), .estado_dbg(estado_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [W-1:0] mk(input int c, input logic [2:0] id,
    input logic ra, input logic le, input logic [3:0] s, input logic ly,
    input logic de, input logic [5:0] dn, input logic tl, input logic oc,
    input logic ov);
    return {16'(c), id, ra, le, s, ly, de, dn, tl, oc, ov};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Expected words for one frame; words at cycles >= lim are not queued.
  task automatic push_frame(input int start, input logic [5:0] mask,
                            input int ovr_at, input int lim);
    int c;
    int last;
    c = start;
    last = -1;
    for (int i = 0; i < 6; i++) if (mask[i]) last = i;
    for (int i = 0; i < 6; i++) begin
      if (mask[i]) begin
        if (c < lim) exp_q.push_back(mk(c, 3'(i), 1, 0, 4'd0, 0, 0, 6'd0, 0, 1, c >= ovr_at));
        c++;
        for (int k = 0; k < NT; k++) begin
          if (c < lim) exp_q.push_back(mk(c, 3'(i), 0, 1, 4'(k), 0, 0, 6'd0, 0, 1, c >= ovr_at));
          c++;
        end
        if (c < lim) exp_q.push_back(mk(c, 3'(i), 0, 0, 4'd0, 1, 0, 6'd0, 0, 1, c >= ovr_at));
        c++;
        if (c < lim) exp_q.push_back(mk(c, 3'(i), 0, 0, 4'd0, 0, 1, 6'(1 << i), i == last, 1, c >= ovr_at));
        c++;
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    if (ocupado || trama_lista || rst_acum || leer || leer_y || desp) begin
      got = mk(cyc, ocupado ? stage_id : 3'd0, rst_acum, leer, sel, leer_y, desp,
               stage_done, trama_lista, ocupado, overrun);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL trace_extra cyc=%0d got=%h exp=none", cyc, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL trace cyc=%0d got=%h exp=%h", cyc, got, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ml();
    muestra_lista = 1'b1;
    @(posedge clk);
    #1;
    muestra_lista = 1'b0;
  endtask

  task automatic sample(input logic [5:0] en, output int p);
    stage_en = en;
    p = cyc;
    pulse_ml();
  endtask

  task automatic check_quiet(input string name);
    check({name, "_strobes"}, {26'd0, rst_acum, leer, leer_y, desp, trama_lista, ocupado}, 32'd0);
    check({name, "_sel"}, {28'd0, sel}, 32'd0);
    check({name, "_done"}, {26'd0, stage_done}, 32'd0);
    check({name, "_id_state"}, {26'd0, stage_id, estado_dbg}, 32'd0);
    check({name, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p;
    rst = 1'b0;
    muestra_lista = 1'b0;
    stage_en = 6'd0;
    clr_overrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Full frame: 6 stages x 8 cycles.
    sample(6'b111111, p);
    push_frame(p + 1, 6'b111111, BIG, BIG);
    goto(p + 55);

    // Skipping: stages 2 and 5 only.
    sample(6'b100100, p);
    push_frame(p + 1, 6'b100100, BIG, BIG);
    goto(p + 22);

    // Empty mask: lone trama_lista pulse one cycle after accept.
    sample(6'b000000, p);
    exp_q.push_back(mk(p + 1, 3'd0, 0, 0, 4'd0, 0, 0, 6'd0, 1, 0, 0));
    goto(p + 4);

    // Back-to-back: pend at p+5, overrun at p+9, pending frame follows final DESP.
    sample(6'b000011, p);
    push_frame(p + 1,  6'b000011, p + 10, BIG);
    push_frame(p + 17, 6'b000011, p + 10, BIG);
    goto(p + 5);
    pulse_ml();
    goto(p + 9);
    pulse_ml();
    goto(p + 40);
    check("overrun_held", {31'd0, overrun}, 32'd1);
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    clr_overrun = 1'b0;
    check("overrun_cleared", {31'd0, overrun}, 32'd0);

    // Boundary: strobe in the final DESP cycle restarts without an IDLE cycle.
    sample(6'b000100, p);
    push_frame(p + 1, 6'b000100, BIG, BIG);
    goto(p + 8);
    pulse_ml();
    push_frame(p + 9, 6'b000100, BIG, BIG);
    goto(p + 20);

    // Reset mid-MAC at sel=3 of stage 1.
    sample(6'b000011, p);
    push_frame(p + 1, 6'b000011, BIG, p + 13);
    goto(p + 13);
    rst = 1'b0;
    #1;
    check_quiet("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", {29'd0, estado_dbg}, {29'd0, S_IDLE});
    sample(6'b000011, p);
    push_frame(p + 1, 6'b000011, BIG, BIG);
    goto(p + 20);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
